// File: rtl/id_stage_hs_pkg.sv
// id_stage_hs_pkg: opcodes, ALU control encodings, instruction field positions and register-use helpers
package id_stage_hs_pkg;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int ALT_BIT = 30;
  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_J      = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_U      = 7'b0110111,
    OP_UPC    = 7'b0010111
  } opcode_e;
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_ctrl_e;
  function automatic logic rs1_used(input logic [6:0] op);
    return !(op inside {OP_U, OP_UPC, OP_J});
  endfunction
  function automatic logic rs2_used(input logic [6:0] op);
    return op inside {OP_R, OP_STORE, OP_BRANCH};
  endfunction
endpackage

// File: rtl/control_unit.sv
// control_unit: ALU operation select from opcode, func3 and instr[30]
module control_unit import id_stage_hs_pkg::*; (
  input  logic [6:0] opcode_i,
  input  logic [2:0] func3_i,
  input  logic       alt_i,
  output logic [3:0] alu_ctrl_o
);
  alu_ctrl_e f3_op;
  always_comb begin
    f3_op = ALU_AND;
    case (func3_i)
      3'b000: f3_op = (opcode_i == OP_R && alt_i) ? ALU_SUB : ALU_ADD;
      3'b001: f3_op = ALU_SLL;
      3'b010: f3_op = ALU_SLT;
      3'b011: f3_op = ALU_SLTU;
      3'b100: f3_op = ALU_XOR;
      3'b101: f3_op = alt_i ? ALU_SRA : ALU_SRL;
      3'b110: f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
    alu_ctrl_o = (opcode_i == OP_R || opcode_i == OP_I) ? f3_op :
                 (opcode_i == OP_U)      ? ALU_PASSB :
                 (opcode_i == OP_BRANCH) ? ALU_SUB : ALU_ADD;
  end
endmodule

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate for every instruction format
module imm_gen import id_stage_hs_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o
);
  logic [6:0]  op;
  logic [31:0] imm32;
  assign op = instr_i[6:0];
  always_comb begin
    imm32 = (op == OP_I || op == OP_LOAD || op == OP_JALR) ? {{20{instr_i[31]}}, instr_i[31:20]} :
            (op == OP_STORE)  ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
            (op == OP_BRANCH) ? {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
            (op == OP_U || op == OP_UPC) ? {instr_i[31:12], 12'b0} :
            (op == OP_J) ? {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} :
            32'b0;
  end
  assign imm_o = XLEN'($signed(imm32));
endmodule

// File: rtl/regfile_bypass.sv
// regfile_bypass: 2R1W register file, x0 hardwired to zero, optional write-to-read bypass
module regfile_bypass #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ra1_i,
  input  logic [4:0]      ra2_i,
  input  logic            wr_i,
  input  logic [4:0]      wa_i,
  input  logic [XLEN-1:0] wd_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o
);
  localparam int AW = $clog2(NREG);
  logic [XLEN-1:0] regs_q [NREG];
  logic            we;
  assign we = wr_i && wa_i != 5'd0 && 32'(wa_i) < NREG;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    else if (we) regs_q[wa_i[AW-1:0]] <= wd_i;
  end
  // only accepted writes are forwarded, so x0 and out-of-range indices still read 0
  assign rd1_o = (BYPASS != 0 && we && wa_i == ra1_i) ? wd_i :
                 (ra1_i != 5'd0 && 32'(ra1_i) < NREG) ? regs_q[ra1_i[AW-1:0]] : '0;
  assign rd2_o = (BYPASS != 0 && we && wa_i == ra2_i) ? wd_i :
                 (ra2_i != 5'd0 && 32'(ra2_i) < NREG) ? regs_q[ra2_i[AW-1:0]] : '0;
endmodule

// File: rtl/id_stage_hs.sv
// id_stage_hs: handshaked decode stage with load-use interlock, flush and ID/EX register
module id_stage_hs import id_stage_hs_pkg::*; #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_if_valid,
  output logic              o_if_ready,
  input  logic [31:0]       i_if_instr,
  input  logic [ADDR_W-1:0] i_if_pc,
  input  logic              i_flush,
  input  logic              i_wb_wr,
  input  logic [4:0]        i_wb_rd,
  input  logic [XLEN-1:0]   i_wb_data,
  input  logic              i_ex_ready,
  output logic              o_id_valid,
  output logic [XLEN-1:0]   o_rs1_data,
  output logic [XLEN-1:0]   o_rs2_data,
  output logic [XLEN-1:0]   o_imm,
  output logic [4:0]        o_rs1,
  output logic [4:0]        o_rs2,
  output logic [4:0]        o_rd,
  output logic [6:0]        o_opcode,
  output logic [2:0]        o_func3,
  output logic [3:0]        o_alu_ctrl,
  output logic [ADDR_W-1:0] o_pc
);
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [3:0]        alu_ctrl;
  } idex_t;
  logic [6:0]      opc;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic [XLEN-1:0] rs1_data, rs2_data, imm;
  logic [3:0]      alu;
  logic            hazard, advance, load, valid_q, valid_d;
  idex_t           idex_q, idex_d;
  assign opc = i_if_instr[6:0];
  assign rd  = i_if_instr[RD_LSB +: 5];
  assign f3  = i_if_instr[F3_LSB +: 3];
  assign rs1 = i_if_instr[RS1_LSB +: 5];
  assign rs2 = i_if_instr[RS2_LSB +: 5];
  regfile_bypass #(.XLEN(XLEN), .NREG(NREG), .BYPASS(BYPASS)) u_rf (
    .clk(clk), .rst_n(rst_n), .ra1_i(rs1), .ra2_i(rs2),
    .wr_i(i_wb_wr), .wa_i(i_wb_rd), .wd_i(i_wb_data), .rd1_o(rs1_data), .rd2_o(rs2_data)
  );
  imm_gen #(.XLEN(XLEN)) u_imm (.instr_i(i_if_instr), .imm_o(imm));
  control_unit u_ctrl (.opcode_i(opc), .func3_i(f3), .alt_i(i_if_instr[ALT_BIT]), .alu_ctrl_o(alu));
  // a load in ID/EX has no data yet, so a dependent reader waits until it has moved on
  assign hazard = i_if_valid & valid_q & (idex_q.opcode == OP_LOAD) & (idex_q.rd != 5'd0) &
                  ((rs1_used(opc) & (rs1 == idex_q.rd)) | (rs2_used(opc) & (rs2 == idex_q.rd)));
  assign advance    = ~valid_q | i_ex_ready;
  assign o_if_ready = advance & ~hazard & ~i_flush;
  assign load       = o_if_ready & i_if_valid;
  always_comb begin
    valid_d = i_flush ? 1'b0 : advance ? load : valid_q;
    idex_d  = load ? '{i_if_pc, rs1_data, rs2_data, imm, rs1, rs2, rd, opc, f3, alu} : idex_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idex_q  <= idex_d;
    end
  end
  assign o_id_valid = valid_q;
  assign o_pc       = idex_q.pc;
  assign o_rs1_data = idex_q.rs1_data;
  assign o_rs2_data = idex_q.rs2_data;
  assign o_imm      = idex_q.imm;
  assign o_rs1      = idex_q.rs1;
  assign o_rs2      = idex_q.rs2;
  assign o_rd       = idex_q.rd;
  assign o_opcode   = idex_q.opcode;
  assign o_func3    = idex_q.func3;
  assign o_alu_ctrl = idex_q.alu_ctrl;
endmodule

// File: tb/tb_id_stage_hs.sv
// tb_id_stage_hs: directed stimulus with a scoreboard of decoded packets checked at every EX transfer
module tb_id_stage_hs;
  import id_stage_hs_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_if_valid = 1'b0, i_flush = 1'b0, i_wb_wr = 1'b0, i_ex_ready = 1'b1;
  logic [31:0] i_if_instr = '0, i_if_pc = '0, i_wb_data = '0;
  logic [4:0]  i_wb_rd = '0;
  logic        o_if_ready, o_id_valid, n_if_ready, n_id_valid;
  logic [31:0] o_rs1_data, o_rs2_data, o_imm, o_pc, n_rs1_data, n_rs2_data, n_imm, n_pc;
  logic [4:0]  o_rs1, o_rs2, o_rd, n_rs1, n_rs2, n_rd;
  logic [6:0]  o_opcode, n_opcode;
  logic [2:0]  o_func3, n_func3;
  logic [3:0]  o_alu_ctrl, n_alu_ctrl;
  always #5 clk = ~clk;
  id_stage_hs #(.XLEN(32), .ADDR_W(32), .NREG(32), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_if_valid(i_if_valid), .o_if_ready(o_if_ready),
    .i_if_instr(i_if_instr), .i_if_pc(i_if_pc), .i_flush(i_flush), .i_wb_wr(i_wb_wr),
    .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .i_ex_ready(i_ex_ready), .o_id_valid(o_id_valid),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_imm(o_imm), .o_rs1(o_rs1),
    .o_rs2(o_rs2), .o_rd(o_rd), .o_opcode(o_opcode), .o_func3(o_func3),
    .o_alu_ctrl(o_alu_ctrl), .o_pc(o_pc)
  );
  id_stage_hs #(.XLEN(32), .ADDR_W(32), .NREG(16), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .i_if_valid(i_if_valid), .o_if_ready(n_if_ready),
    .i_if_instr(i_if_instr), .i_if_pc(i_if_pc), .i_flush(i_flush), .i_wb_wr(i_wb_wr),
    .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .i_ex_ready(i_ex_ready), .o_id_valid(n_id_valid),
    .o_rs1_data(n_rs1_data), .o_rs2_data(n_rs2_data), .o_imm(n_imm), .o_rs1(n_rs1),
    .o_rs2(n_rs2), .o_rd(n_rd), .o_opcode(n_opcode), .o_func3(n_func3),
    .o_alu_ctrl(n_alu_ctrl), .o_pc(n_pc)
  );
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, d1, d2;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [3:0]  alu;
  } pkt_t;
  pkt_t sb[$];
  int   total = 0, bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    pkt_t a, e;
    if (rst_n && o_id_valid && i_ex_ready) begin
      a = '{o_pc, o_rd, o_rs1, o_rs2, o_imm, o_rs1_data, o_rs2_data, o_opcode, o_func3, o_alu_ctrl};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got pc %h expected no transfer", o_pc);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL sb_pkt pc=%h: got %h expected %h", e.pc, a, e);
        end
      end
    end
  end
  task automatic wb(input logic [4:0] idx, input logic [31:0] data);
    i_wb_wr = 1'b1; i_wb_rd = idx; i_wb_data = data;
    @(posedge clk); #1;
    i_wb_wr = 1'b0;
  endtask
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] alu,
                       input bit push, output int n);
    bit ok;
    if (push) sb.push_back('{pc, ins[11:7], ins[19:15], ins[24:20], imm, d1, d2, ins[6:0], ins[14:12], alu});
    i_if_instr = ins; i_if_pc = pc; i_if_valid = 1'b1;
    ok = 1'b0; n = 0;
    for (int k = 1; k <= 20 && !ok; k++) begin
      @(negedge clk);
      n = k;
      ok = o_if_ready;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept pc=%h: got not-ready expected ready within 20 cycles", pc);
    end
    @(posedge clk); #1;
    i_if_valid = 1'b0;
  endtask
  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", o_id_valid, 0);
    check("rst_pc", o_pc, 0);
    check("rst_imm", o_imm, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", o_if_ready, 1);
    @(posedge clk); #1;
    wb(5'd2, 32'h40); wb(5'd3, 32'd3); wb(5'd4, 32'd4); wb(5'd20, 32'h1234); wb(5'd0, 32'h55);
    issue(32'h00500093, 32'h100, 32'd5, 0, 0, ALU_ADD, 1, n);
    check("addi_cycles", n, 1);
    @(negedge clk);
    check("addi_valid", o_id_valid, 1);
    check("addi_rd", o_rd, 1);
    check("addi_imm", o_imm, 5);
    check("addi_pc", o_pc, 32'h100);
    check("addi_ready", o_if_ready, 1);
    @(posedge clk); #1;
    issue(32'h40418533, 32'h104, 0, 3, 4, ALU_SUB, 1, n);
    i_ex_ready = 1'b0;
    fork
      issue(32'hFE312E23, 32'h108, 32'hFFFFFFFC, 32'h40, 3, ALU_ADD, 1, n);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_ready", o_if_ready, 0);
          check("stall_valid", o_id_valid, 1);
          check("stall_pc", o_pc, 32'h104);
          check("stall_rs2d", o_rs2_data, 4);
        end
        @(posedge clk); #1;
        i_ex_ready = 1'b1;
      end
    join
    check("stall_cycles", n, 4);
    issue(32'h00012283, 32'h10C, 0, 32'h40, 0, ALU_ADD, 1, n);
    check("lw_cycles", n, 1);
    fork
      issue(32'h00328333, 32'h110, 0, 0, 3, ALU_ADD, 1, n);
      begin
        @(negedge clk);
        check("lu_hazard_ready", o_if_ready, 0);
        @(negedge clk);
        check("lu_bubble", o_id_valid, 0);
      end
    join
    check("lu_cycles", n, 2);
    issue(32'h00012283, 32'h114, 0, 32'h40, 0, ALU_ADD, 1, n);
    issue(32'h00320333, 32'h118, 0, 4, 3, ALU_ADD, 1, n);
    check("nodep_cycles", n, 1);
    issue(32'h00012283, 32'h11C, 0, 32'h40, 0, ALU_ADD, 1, n);
    i_ex_ready = 1'b0;
    fork
      issue(32'h00328333, 32'h120, 0, 0, 3, ALU_ADD, 1, n);
      begin
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        i_ex_ready = 1'b1;
      end
    join
    check("lu_held_cycles", n, 4);
    i_wb_wr = 1'b1; i_wb_rd = 5'd7; i_wb_data = 32'hDEADBEEF;
    issue(32'h00038413, 32'h124, 0, 32'hDEADBEEF, 0, ALU_ADD, 1, n);
    i_wb_wr = 1'b0;
    check("byp_cycles", n, 1);
    @(negedge clk);
    check("byp_on_rs1", o_rs1_data, 32'hDEADBEEF);
    check("byp_off_rs1", n_rs1_data, 0);
    @(posedge clk); #1;
    issue(32'h014004B3, 32'h128, 0, 0, 32'h1234, ALU_ADD, 1, n);
    @(negedge clk);
    check("x20_n32", o_rs2_data, 32'h1234);
    check("x20_n16", n_rs2_data, 0);
    check("x0_n16", n_rs1_data, 0);
    @(posedge clk); #1;
    issue(32'h123455B7, 32'h12C, 32'h12345000, 0, 3, ALU_PASSB, 1, n);
    issue(32'h00500093, 32'h130, 32'd5, 0, 0, ALU_ADD, 0, n);
    i_ex_ready = 1'b0; i_flush = 1'b1;
    i_if_valid = 1'b1; i_if_instr = 32'h00500093; i_if_pc = 32'h134;
    @(negedge clk);
    check("flush_ready", o_if_ready, 0);
    check("flush_pre_valid", o_id_valid, 1);
    @(posedge clk); #1;
    i_flush = 1'b0; i_ex_ready = 1'b1; i_if_valid = 1'b0;
    @(negedge clk);
    check("flush_kill", o_id_valid, 0);
    @(posedge clk); #1;
    issue(32'h00500093, 32'h134, 32'd5, 0, 0, ALU_ADD, 1, n);
    check("flush_next_cycles", n, 1);
    issue(32'h00500093, 32'h138, 32'd5, 0, 0, ALU_ADD, 0, n);
    i_ex_ready = 1'b0;
    i_if_valid = 1'b1; i_if_instr = 32'h00038413; i_if_pc = 32'h13C;
    @(posedge clk); #2;
    rst_n = 1'b0; i_if_valid = 1'b0;
    #1;
    check("arst_valid", o_id_valid, 0);
    check("arst_pc", o_pc, 0);
    check("arst_imm", o_imm, 0);
    check("arst_rd", o_rd, 0);
    check("arst_opcode", o_opcode, 0);
    i_ex_ready = 1'b1;
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("arst_rel_ready", o_if_ready, 1);
    @(posedge clk); #1;
    issue(32'h00038413, 32'h13C, 0, 0, 0, ALU_ADD, 1, n);
    repeat (3) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
